counter_tick_sequencer: RTL and testbench

//  Upstream control stage for the 4-bit up-counter family; drives the counter's clock-enable and load inputs.

---
 rtl/counter_tick_sequencer.sv | 106 ++++++++++
 tb/tb_counter_tick_sequencer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/counter_tick_sequencer.sv
// Control stage for the 4-bit up-counter family. It divides clk by a programmable prescale,
// issues count-enable / load strobes, and tracks a shadow count to detect terminal count.
module counter_tick_sequencer #(
    parameter int WIDTH   = 4,
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [WIDTH-1:0]   load_val,
    input  logic [PRESC_W-1:0] prescale,
    output logic               cnt_ce,
    output logic               cnt_ld,
    output logic [WIDTH-1:0]   cnt_d,
    output logic               busy,
    output logic               done,
    output logic               tc_pulse
);

    // state | meaning
    // IDLE  | waiting for start; no strobes
    // RUN   | prescaling and issuing count enables
    // DONE  | one-shot expired; done held high until restart or stop
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    logic [1:0]         state;
    logic               mode_r;
    logic [WIDTH-1:0]   load_val_r;
    logic [PRESC_W-1:0] prescale_r;
    logic [PRESC_W-1:0] presc_cnt;
    logic [WIDTH-1:0]   shadow;

    always_ff @(posedge clk) begin
        if (clr) begin
            state      <= IDLE;
            mode_r     <= 1'b0;
            load_val_r <= '0;
            prescale_r <= '0;
            presc_cnt  <= '0;
            shadow     <= '0;
            cnt_ce     <= 1'b0;
            cnt_ld     <= 1'b0;
            cnt_d      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            tc_pulse   <= 1'b0;
        end else begin
            // strobes are single-cycle pulses unless re-asserted below
            cnt_ce   <= 1'b0;
            cnt_ld   <= 1'b0;
            tc_pulse <= 1'b0;
            if (stop) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (start) begin
                            mode_r     <= mode;
                            load_val_r <= load_val;
                            prescale_r <= prescale;
                            cnt_ld     <= 1'b1;
                            cnt_d      <= load_val;
                            shadow     <= load_val;
                            presc_cnt  <= '0;
                            busy       <= 1'b1;
                            done       <= 1'b0;
                            state      <= RUN;
                        end
                    end
                    RUN: begin
                        if (presc_cnt == prescale_r) begin
                            presc_cnt <= '0;
                            if (shadow == ALL_ONES) begin
                                tc_pulse <= 1'b1;
                                if (mode_r) begin
                                    cnt_ld <= 1'b1;
                                    cnt_d  <= load_val_r;
                                    shadow <= load_val_r;
                                end else begin
                                    state <= DONE;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end
                            end else begin
                                cnt_ce <= 1'b1;
                                shadow <= shadow + WIDTH'(1);
                            end
                        end else begin
                            presc_cnt <= presc_cnt + PRESC_W'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_counter_tick_sequencer.sv
// Self-checking bench for counter_tick_sequencer: per-edge directed vector table plus
// a hand-written full-period sequence.
module tb_counter_tick_sequencer;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       mode = 1'b0;
    logic [3:0] load_val = '0;
    logic [7:0] prescale = '0;
    logic       cnt_ce, cnt_ld, busy, done, tc_pulse;
    logic [3:0] cnt_d;

    int errors = 0;
    int checks = 0;

    counter_tick_sequencer #(.WIDTH(4), .PRESC_W(8)) dut (
        .clk(clk), .clr(clr), .start(start), .stop(stop), .mode(mode),
        .load_val(load_val), .prescale(prescale),
        .cnt_ce(cnt_ce), .cnt_ld(cnt_ld), .cnt_d(cnt_d),
        .busy(busy), .done(done), .tc_pulse(tc_pulse)
    );

    always #5 clk = ~clk;

    // one record = inputs applied before an edge, outputs expected just after it
    typedef struct {
        logic       clr, start, stop, mode;
        logic [3:0] lv;
        logic [7:0] ps;
        logic       ce, ld;
        logic [3:0] d;
        logic       busy, done, tc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic c, s, p, m, input logic [3:0] lv, input logic [7:0] ps,
                               input logic ce, ld, input logic [3:0] d, input logic b, dn, tc);
        vec_t r;
        r.clr = c; r.start = s; r.stop = p; r.mode = m; r.lv = lv; r.ps = ps;
        r.ce = ce; r.ld = ld; r.d = d; r.busy = b; r.done = dn; r.tc = tc;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        int n, ces, overlap;
        bit got;

        //                 clr st sp md lv  ps   ce ld d   busy done tc
        vecs.push_back(v(1, 0, 0, 0, 0,  0,   0, 0, 0,  0, 0, 0));
        // one-shot, load 13, prescale 0; later input changes must be ignored
        vecs.push_back(v(0, 1, 0, 0, 13, 0,   0, 1, 13, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 5,  7,   1, 0, 0,  1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 5,  7,   1, 0, 0,  1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 5,  7,   0, 0, 0,  0, 1, 1));
        vecs.push_back(v(0, 0, 0, 0, 5,  7,   0, 0, 0,  0, 1, 0));
        // auto-reload restart from DONE; start held in RUN is ignored
        vecs.push_back(v(0, 1, 0, 1, 13, 0,   0, 1, 13, 1, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 2,  0,   1, 0, 0,  1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 2,  0,   1, 0, 0,  1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 2,  0,   0, 1, 13, 1, 0, 1));
        vecs.push_back(v(0, 0, 0, 0, 2,  0,   1, 0, 0,  1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 2,  0,   1, 0, 0,  1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 2,  0,   0, 1, 13, 1, 0, 1));
        // stop on a tick edge
        vecs.push_back(v(0, 0, 1, 0, 2,  0,   0, 0, 0,  0, 0, 0));
        // prescale 3, load 14, one-shot
        vecs.push_back(v(0, 1, 0, 0, 14, 3,   0, 1, 14, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 14, 3,   0, 0, 0,  1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 14, 3,   0, 0, 0,  1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 14, 3,   0, 0, 0,  1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 14, 3,   1, 0, 0,  1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 14, 3,   0, 0, 0,  1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 14, 3,   0, 0, 0,  1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 14, 3,   0, 0, 0,  1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 14, 3,   0, 0, 0,  0, 1, 1));
        // load all-ones: terminal count on the first tick
        vecs.push_back(v(0, 1, 0, 0, 15, 0,   0, 1, 15, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 15, 0,   0, 0, 0,  0, 1, 1));
        // stop clears done; start with stop stays idle
        vecs.push_back(v(0, 0, 1, 0, 15, 0,   0, 0, 0,  0, 0, 0));
        vecs.push_back(v(0, 1, 1, 0, 6,  0,   0, 0, 0,  0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 6,  0,   0, 0, 0,  0, 0, 0));
        // stop beats a terminal count
        vecs.push_back(v(0, 1, 0, 0, 15, 0,   0, 1, 15, 1, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 15, 0,   0, 0, 0,  0, 0, 0));
        // clr mid-run with prescale 2, then a fresh start
        vecs.push_back(v(0, 1, 0, 1, 3,  2,   0, 1, 3,  1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 3,  2,   0, 0, 0,  1, 0, 0));
        vecs.push_back(v(1, 0, 0, 1, 3,  2,   0, 0, 0,  0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 9,  0,   0, 0, 0,  0, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 9,  0,   0, 1, 9,  1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 9,  0,   1, 0, 0,  1, 0, 0));

        foreach (vecs[i]) begin
            @(negedge clk);
            clr = vecs[i].clr; start = vecs[i].start; stop = vecs[i].stop;
            mode = vecs[i].mode; load_val = vecs[i].lv; prescale = vecs[i].ps;
            @(posedge clk);
            #1;
            chk($sformatf("row%0d cnt_ce", i), cnt_ce, vecs[i].ce);
            chk($sformatf("row%0d cnt_ld", i), cnt_ld, vecs[i].ld);
            chk($sformatf("row%0d busy", i), busy, vecs[i].busy);
            chk($sformatf("row%0d done", i), done, vecs[i].done);
            chk($sformatf("row%0d tc_pulse", i), tc_pulse, vecs[i].tc);
            if (vecs[i].ld || vecs[i].clr)
                chk($sformatf("row%0d cnt_d", i), cnt_d, vecs[i].d);
        end

        // full one-shot period: load 0, prescale 1 -> 16 ticks, 32 cycles, 15 enables
        @(negedge clk);
        clr = 0; start = 0; stop = 1;
        @(negedge clk);
        stop = 0; start = 1; mode = 0; load_val = 4'd0; prescale = 8'd1;
        @(posedge clk);
        #1;
        chk("period load strobe", cnt_ld, 1);
        chk("period load data", cnt_d, 0);
        @(negedge clk);
        start = 0;
        n = 0; ces = 0; overlap = 0; got = 0;
        for (int k = 1; k <= 100 && !got; k++) begin
            if (k > 1) @(posedge clk);
            else @(posedge clk);
            #1;
            if (cnt_ce) ces++;
            if (cnt_ce && cnt_ld) overlap++;
            if (done) begin
                got = 1;
                n = k;
            end
        end
        chk("period done reached", got, 1);
        chk("period cycles to done", n, 32);
        chk("period enable count", ces, 15);
        chk("period ce/ld overlap", overlap, 0);
        chk("period tc_pulse", tc_pulse, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
